// File: rtl/tbus_mem_responder_pkg.sv
// tbus_mem_responder_pkg: tbus operation defines and responder state encodings
`ifndef TBUS_DEFINES
`define TBUS_DEFINES
`define TBUS_OPTYPE_RANGE 1:0
`define TBUS_READ 2'b00
`define TBUS_WRITE 2'b01
`define RESULT_RANGE 63:0
`endif
package tbus_mem_responder_pkg;
  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_IDLE = 2'b01,
    S_BUSY = 2'b10,
    S_DONE = 2'b11
  } resp_state_t;
  localparam logic [`TBUS_OPTYPE_RANGE] OP_READ  = `TBUS_READ;
  localparam logic [`TBUS_OPTYPE_RANGE] OP_WRITE = `TBUS_WRITE;
endpackage

// File: rtl/tbus_mem_responder_sram.sv
// tbus_sram: DEPTH x 64 single-port array, combinational read, bit-masked synchronous write, clear port
module tbus_sram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clock,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic                     i_we,
  input  logic                     i_clr,
  input  logic [63:0]              i_wdata,
  input  logic [63:0]              i_wmask,
  output logic [63:0]              o_rdata
);
  logic [63:0] r_mem [DEPTH];
  assign o_rdata = r_mem[i_idx];
  always_ff @(posedge clock)
    if (i_clr) r_mem[i_idx] <= '0;
    else if (i_we) r_mem[i_idx] <= (r_mem[i_idx] & ~i_wmask) | (i_wdata & i_wmask);
endmodule

// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: tbus responder serving one request at a time from a 64-bit-word array
module tbus_mem_responder
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tbus_index_valid,
  output logic                      tbus_index_ready,
  input  logic [63:0]               tbus_index,
  input  logic [63:0]               tbus_write_data,
  input  logic [63:0]               tbus_write_mask,
  input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
  output logic [`RESULT_RANGE]      tbus_read_data,
  output logic                      tbus_operation_done,
  input  logic                      flush_valid,
  input  logic                      resp_stall
);
  localparam int AW = $clog2(DEPTH);
  resp_state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [AW-1:0] r_init_idx, r_idx;
  logic [`TBUS_OPTYPE_RANGE] r_op;
  logic [63:0] r_wdata, r_wmask, r_rdata, w_mem_rdata;
  logic r_kill, w_fire, w_is_wr, w_done_st, w_unused;
  assign w_fire   = tbus_index_valid & tbus_index_ready;
  assign w_is_wr  = r_op == OP_WRITE;
  assign w_unused = ^{tbus_index[63:3+AW], tbus_index[2:0]};
  always_ff @(posedge clock) r_state <= reset ? (INIT_ZERO ? S_INIT : S_IDLE) : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  w_next = (r_init_idx == AW'(DEPTH-1)) ? S_IDLE : S_INIT;
      S_IDLE:  w_next = w_fire ? ((LATENCY == 1) ? S_DONE : S_BUSY) : S_IDLE;
      S_BUSY:  w_next = (r_cnt == 4'd1) ? S_DONE : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  // A read is killed by a flush seen in BUSY (latched) or in the DONE cycle itself; writes always complete.
  always_comb begin
    tbus_index_ready    = (r_state == S_IDLE) & ~resp_stall & ~flush_valid & ~reset;
    w_done_st           = (r_state == S_DONE) & ~reset;
    tbus_operation_done = w_done_st & ~r_kill & (w_is_wr | ~flush_valid);
    tbus_read_data      = w_done_st ? w_mem_rdata : r_rdata;
  end
  always_ff @(posedge clock)
    if (reset) begin
      r_cnt      <= '0;
      r_init_idx <= '0;
      r_idx      <= '0;
      r_op       <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_rdata    <= '0;
      r_kill     <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_init_idx <= r_init_idx + 1'b1;
      if (w_fire) begin
        r_idx   <= tbus_index[3 +: AW];
        r_op    <= tbus_operation_type;
        r_wdata <= tbus_write_data;
        r_wmask <= tbus_write_mask;
        r_cnt   <= 4'(LATENCY - 1);
        r_kill  <= 1'b0;
      end else if (r_state == S_BUSY) begin
        r_cnt  <= r_cnt - 1'b1;
        r_kill <= r_kill | (flush_valid & ~w_is_wr);
      end
      if (w_done_st) r_rdata <= w_mem_rdata;
    end
  tbus_sram #(.DEPTH(DEPTH)) u_sram (
    .clock   (clock),
    .i_idx   ((r_state == S_INIT) ? r_init_idx : r_idx),
    .i_we    (w_done_st & w_is_wr),
    .i_clr   ((r_state == S_INIT) & ~reset),
    .i_wdata (r_wdata),
    .i_wmask (r_wmask),
    .o_rdata (w_mem_rdata)
  );
endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb_tbus_mem_responder: directed checks of a LATENCY=2 and a LATENCY=1 responder
module tb_tbus_mem_responder;
  import tbus_mem_responder_pkg::*;
  logic clock = 1'b0, reset;
  logic a_valid, a_ready, a_done, a_flush, a_stall;
  logic [63:0] a_index, a_wdata, a_wmask, a_rdata;
  logic [1:0] a_op;
  logic b_valid, b_ready, b_done;
  logic [63:0] b_index, b_wdata, b_rdata;
  logic [1:0] b_op;
  int n_chk = 0, n_fail = 0, n_hi = 0;
  always #5 clock = ~clock;
  tbus_mem_responder #(.DEPTH(1024), .LATENCY(2), .INIT_ZERO(1'b1)) u_dut_a (
    .clock(clock), .reset(reset), .tbus_index_valid(a_valid), .tbus_index_ready(a_ready),
    .tbus_index(a_index), .tbus_write_data(a_wdata), .tbus_write_mask(a_wmask),
    .tbus_operation_type(a_op), .tbus_read_data(a_rdata), .tbus_operation_done(a_done),
    .flush_valid(a_flush), .resp_stall(a_stall));
  tbus_mem_responder #(.DEPTH(1024), .LATENCY(1), .INIT_ZERO(1'b1)) u_dut_b (
    .clock(clock), .reset(reset), .tbus_index_valid(b_valid), .tbus_index_ready(b_ready),
    .tbus_index(b_index), .tbus_write_data(b_wdata), .tbus_write_mask('1),
    .tbus_operation_type(b_op), .tbus_read_data(b_rdata), .tbus_operation_done(b_done),
    .flush_valid(1'b0), .resp_stall(1'b0));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic a_drive(input logic [1:0] op, input logic [63:0] idx, input logic [63:0] d, input logic [63:0] m);
    a_valid = 1'b1;
    a_op = op;
    a_index = idx;
    a_wdata = d;
    a_wmask = m;
  endtask
  // Uninterrupted LATENCY=2 transaction: accept in T, done in T+2, ready again in T+3.
  task automatic a_txn(input string tag, input logic [1:0] op, input logic [63:0] idx,
                       input logic [63:0] d, input logic [63:0] m, input logic [63:0] exp_rd);
    a_drive(op, idx, d, m);
    #1 chk({tag, "_ready_T"}, 64'(a_ready), 64'd1);
    tick;
    a_valid = 1'b0;
    #1 chk({tag, "_ready_T1"}, 64'(a_ready), 64'd0);
    chk({tag, "_done_T1"}, 64'(a_done), 64'd0);
    tick;
    chk({tag, "_ready_T2"}, 64'(a_ready), 64'd0);
    chk({tag, "_done_T2"}, 64'(a_done), 64'd1);
    chk({tag, "_rdata"}, a_rdata, exp_rd);
    tick;
    chk({tag, "_done_T3"}, 64'(a_done), 64'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_flush = 1'b0; a_stall = 1'b0; a_op = OP_READ;
    a_index = '0; a_wdata = '0; a_wmask = '0;
    b_valid = 1'b0; b_op = OP_READ; b_index = '0; b_wdata = '0;
    repeat (2) tick;
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_rdata", a_rdata, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      #1 if (a_ready | b_ready) n_hi++;
      tick;
    end
    chk("init_ready_low_cycles", 64'(n_hi), 64'd0);
    chk("init_ready_a", 64'(a_ready), 64'd1);
    chk("init_ready_b", 64'(b_ready), 64'd1);
    a_txn("rd_cleared", OP_READ, 64'h40, 64'h0, 64'h0, 64'h0);
    a_txn("wr_full", OP_WRITE, 64'h100, 64'h1122334455667788, '1, 64'h0);
    a_txn("rd_full", OP_READ, 64'h104, 64'h0, 64'h0, 64'h1122334455667788);
    a_txn("wr_mask", OP_WRITE, 64'h100, 64'hAAAAAAAABBBBCCCC, 64'h00000000FFFF0000, 64'h1122334455667788);
    a_txn("rd_mask", OP_READ, 64'h100, 64'h0, 64'h0, 64'h11223344BBBB7788);
    a_txn("illegal_op", 2'b10, 64'h100, 64'h0, '1, 64'h11223344BBBB7788);
    a_txn("rd_after_illegal", OP_READ, 64'h100, 64'h0, 64'h0, 64'h11223344BBBB7788);
    a_stall = 1'b1;
    a_drive(OP_READ, 64'h100, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 64'(a_ready), 64'd0);
      chk("stall_done", 64'(a_done), 64'd0);
      tick;
    end
    a_stall = 1'b0;
    a_txn("rd_after_stall", OP_READ, 64'h100, 64'h0, 64'h0, 64'h11223344BBBB7788);
    a_drive(OP_READ, 64'h100, 64'h0, 64'h0);
    #1 chk("flush_rd_accept", 64'(a_ready), 64'd1);
    tick;
    a_valid = 1'b0;
    a_flush = 1'b1;
    #1 chk("flush_rd_done_T1", 64'(a_done), 64'd0);
    tick;
    a_flush = 1'b0;
    #1 chk("flush_rd_done_T2", 64'(a_done), 64'd0);
    chk("flush_rd_ready_T2", 64'(a_ready), 64'd0);
    tick;
    chk("flush_rd_ready_T3", 64'(a_ready), 64'd1);
    a_drive(OP_READ, 64'h100, 64'h0, 64'h0);
    tick;
    a_valid = 1'b0;
    tick;
    a_flush = 1'b1;
    #1 chk("flush_in_done_rd", 64'(a_done), 64'd0);
    tick;
    a_flush = 1'b0;
    #1 chk("flush_in_done_ready", 64'(a_ready), 64'd1);
    a_drive(OP_WRITE, 64'h200, 64'hDEADBEEFCAFEF00D, '1);
    tick;
    a_valid = 1'b0;
    a_flush = 1'b1;
    #1 chk("flush_wr_done_T1", 64'(a_done), 64'd0);
    tick;
    a_flush = 1'b0;
    #1 chk("flush_wr_done_T2", 64'(a_done), 64'd1);
    tick;
    a_drive(OP_READ, 64'h200, 64'h0, 64'h0);
    a_flush = 1'b1;
    #1 chk("flush_idle_ready", 64'(a_ready), 64'd0);
    tick;
    a_flush = 1'b0;
    a_txn("rd_flushed_wr", OP_READ, 64'h200, 64'h0, 64'h0, 64'hDEADBEEFCAFEF00D);
    b_valid = 1'b1; b_op = OP_WRITE; b_index = 64'h2000; b_wdata = 64'h0123456789ABCDEF;
    #1 chk("b2b_accept0", 64'(b_ready), 64'd1);
    tick;
    b_op = OP_READ; b_index = 64'h0;
    #1 chk("b2b_done1", 64'(b_done), 64'd1);
    chk("b2b_ready1", 64'(b_ready), 64'd0);
    chk("b2b_rdata1", b_rdata, 64'h0);
    tick;
    chk("b2b_accept2", 64'(b_ready), 64'd1);
    tick;
    b_index = 64'h2008;
    #1 chk("b2b_done3", 64'(b_done), 64'd1);
    chk("b2b_ready3", 64'(b_ready), 64'd0);
    chk("b2b_alias_rdata", b_rdata, 64'h0123456789ABCDEF);
    tick;
    chk("b2b_accept4", 64'(b_ready), 64'd1);
    tick;
    b_valid = 1'b0;
    #1 chk("b2b_done5", 64'(b_done), 64'd1);
    chk("b2b_rdata5", b_rdata, 64'h0);
    tick;
    chk("b2b_done6", 64'(b_done), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
